// File: rtl/button_events.sv
// N-channel button conditioner: 2-flop synchroniser, debounce filter and hold FSM
// per channel. Produces a clean level plus 1-cycle press/release/long-press/repeat pulses.
// The release and repeat pulses are named release_ev and repeat_ev because
// "release" and "repeat" are reserved words.
module button_events #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned DEB_DELAY     = 20000,
    parameter int unsigned LONG_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_ev,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_ev
);

    localparam int unsigned DEB_W  = $clog2(DEB_DELAY + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_DELAY + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_PERIOD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } hold_state_e;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    // Two-flop synchroniser; polarity is normalised so 1 always means pressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button ^ {N_BTN{ACTIVE_LOW}};
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DEB_W-1:0]  deb_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [REP_W-1:0]  rep_cnt;
        hold_state_e       state;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              rep_q;
        logic              accept_c;
        logic              rise_c;
        logic              fall_c;

        // The debounced level changes on this edge; rise/fall drive both the pulses and the FSM
        assign accept_c = (sync2[i] != level_q) && (deb_cnt == DEB_W'(DEB_DELAY - 1));
        assign rise_c   = accept_c & sync2[i];
        assign fall_c   = accept_c & ~sync2[i];

        // Debounce filter: count consecutive cycles the input disagrees with level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt <= '0;
                level_q <= 1'b0;
            end else if (sync2[i] == level_q) begin
                deb_cnt <= '0;
            end else if (accept_c) begin
                deb_cnt <= '0;
                level_q <= sync2[i];
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end

        // Hold FSM with registered event pulses; release overrides any pulse due in the same cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                rep_q     <= 1'b0;
            end else begin
                press_q   <= rise_c;
                release_q <= fall_c;
                long_q    <= 1'b0;
                rep_q     <= 1'b0;
                if (fall_c) begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise_c) begin
                                state    <= PRESSED;
                                hold_cnt <= '0;
                            end
                        end
                        PRESSED: begin
                            if (hold_cnt == HOLD_W'(LONG_DELAY - 1)) begin
                                long_q   <= 1'b1;
                                state    <= HELD;
                                hold_cnt <= '0;
                                rep_cnt  <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        HELD: begin
                            if (rep_cnt == REP_W'(REPEAT_PERIOD - 1)) begin
                                rep_cnt <= '0;
                                rep_q   <= REPEAT_EN;
                            end else begin
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end
                        end
                        default: begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                            rep_cnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign level[i]      = level_q;
        assign press[i]      = press_q;
        assign release_ev[i] = release_q;
        assign long_press[i] = long_q;
        assign repeat_ev[i]  = rep_q;
    end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: an active-high and an active-low instance share one
// expected-event scoreboard, so both must produce identical output timing.
module tb_button_events;

    logic       clk;
    logic       rst_n;
    logic [1:0] pins;
    logic [1:0] pins_n;

    logic [1:0] level_a, press_a, rel_a, lp_a, rp_a;
    logic [1:0] level_b, press_b, rel_b, lp_b, rp_b;
    logic [7:0] obs_a, obs_b;

    typedef struct {
        int         cyc;
        logic [7:0] bits;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_total;
    int   n_pass;
    int   press_cyc;

    assign pins_n = ~pins;
    assign obs_a  = {rp_a, lp_a, rel_a, press_a};
    assign obs_b  = {rp_b, lp_b, rel_b, press_b};

    button_events #(
        .N_BTN(2), .DEB_DELAY(4), .LONG_DELAY(10), .REPEAT_PERIOD(3),
        .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .button(pins), .level(level_a), .press(press_a),
        .release_ev(rel_a), .long_press(lp_a), .repeat_ev(rp_a)
    );

    button_events #(
        .N_BTN(2), .DEB_DELAY(4), .LONG_DELAY(10), .REPEAT_PERIOD(3),
        .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .button(pins_n), .level(level_b), .press(press_b),
        .release_ev(rel_b), .long_press(lp_b), .repeat_ev(rp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse vector layout matches obs: {repeat, long_press, release, press}
    function automatic logic [7:0] mk(input logic [1:0] p, input logic [1:0] r,
                                      input logic [1:0] l, input logic [1:0] q);
        return {q, l, r, p};
    endfunction

    task automatic push(input int c, input logic [7:0] b);
        exp_t x;
        x.cyc  = c;
        x.bits = b;
        sb.push_back(x);
    endtask

    // Expected pulses for the current cycle (zero when nothing is scheduled)
    function automatic logic [7:0] pop_exp();
        logic [7:0] e;
        e = '0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e |= sb[0].bits;
            sb.delete(0);
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        pins  = 2'b00;
        @(negedge clk);
        n_total++;
        if ({level_a, obs_a} !== 10'b0) $display("FAIL reset_a got=%b exp=0", {level_a, obs_a});
        else n_pass++;
        n_total++;
        if ({level_b, obs_b} !== 10'b0) $display("FAIL reset_b got=%b exp=0", {level_b, obs_b});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bounce();
        int         c0;
        logic [7:0] e;
        c0 = cyc;
        while (cyc < c0 + 30) begin
            @(negedge clk);
            e = pop_exp();
            n_total += 2;
            if (obs_a !== e) $display("FAIL bounce_a cyc=%0d got=%b exp=%b", cyc, obs_a, e);
            else n_pass++;
            if (obs_b !== e) $display("FAIL bounce_b cyc=%0d got=%b exp=%b", cyc, obs_b, e);
            else n_pass++;
            if (cyc - c0 <= 20) pins[0] = (((cyc - c0 - 1) / 2) % 2) == 0;
            else pins[0] = 1'b0;
        end
        n_total++;
        if (level_a !== 2'b00 || level_b !== 2'b00)
            $display("FAIL bounce_level got=%b/%b exp=00", level_a, level_b);
        else n_pass++;
    endtask

    task automatic test_press();
        int         c0;
        logic [7:0] e;
        c0 = cyc;
        pins[0] = 1'b1;
        press_cyc = c0 + 6;
        push(press_cyc, mk(2'b01, 2'b00, 2'b00, 2'b00));
        while (cyc < c0 + 7) begin
            @(negedge clk);
            e = pop_exp();
            n_total += 2;
            if (obs_a !== e) $display("FAIL press_a cyc=%0d got=%b exp=%b", cyc, obs_a, e);
            else n_pass++;
            if (obs_b !== e) $display("FAIL press_b cyc=%0d got=%b exp=%b", cyc, obs_b, e);
            else n_pass++;
        end
        n_total++;
        if (level_a !== 2'b01 || level_b !== 2'b01)
            $display("FAIL press_level got=%b/%b exp=01", level_a, level_b);
        else n_pass++;
    endtask

    task automatic test_long_repeat();
        int         lp;
        logic [7:0] e;
        lp = press_cyc + 10;
        push(lp,      mk(2'b00, 2'b00, 2'b01, 2'b00));
        push(lp + 3,  mk(2'b00, 2'b00, 2'b00, 2'b01));
        push(lp + 6,  mk(2'b00, 2'b00, 2'b00, 2'b01));
        push(lp + 9,  mk(2'b00, 2'b00, 2'b00, 2'b01));
        push(lp + 12, mk(2'b00, 2'b00, 2'b00, 2'b01));
        // Level falls at lp+15, exactly when the next repeat is due: release wins
        push(lp + 15, mk(2'b00, 2'b01, 2'b00, 2'b00));
        while (cyc < lp + 25) begin
            @(negedge clk);
            e = pop_exp();
            n_total += 2;
            if (obs_a !== e) $display("FAIL long_rep_a cyc=%0d got=%b exp=%b", cyc, obs_a, e);
            else n_pass++;
            if (obs_b !== e) $display("FAIL long_rep_b cyc=%0d got=%b exp=%b", cyc, obs_b, e);
            else n_pass++;
            if (cyc == lp + 9) pins[0] = 1'b0;
        end
        n_total++;
        if (level_a !== 2'b00 || level_b !== 2'b00 || sb.size() != 0)
            $display("FAIL long_rep_end got=%b/%b q=%0d exp=00/0", level_a, level_b, sb.size());
        else n_pass++;
    endtask

    task automatic test_release_at_long();
        int         c0;
        logic [7:0] e;
        c0 = cyc;
        pins[0] = 1'b1;
        push(c0 + 6,  mk(2'b01, 2'b00, 2'b00, 2'b00));
        push(c0 + 16, mk(2'b00, 2'b01, 2'b00, 2'b00));
        while (cyc < c0 + 30) begin
            @(negedge clk);
            e = pop_exp();
            n_total += 2;
            if (obs_a !== e) $display("FAIL rel_vs_long_a cyc=%0d got=%b exp=%b", cyc, obs_a, e);
            else n_pass++;
            if (obs_b !== e) $display("FAIL rel_vs_long_b cyc=%0d got=%b exp=%b", cyc, obs_b, e);
            else n_pass++;
            if (cyc == c0 + 10) pins[0] = 1'b0;
        end
    endtask

    task automatic test_both_channels();
        int         c0;
        logic [7:0] e;
        c0 = cyc;
        pins = 2'b11;
        push(c0 + 6,  mk(2'b11, 2'b00, 2'b00, 2'b00));
        push(c0 + 16, mk(2'b00, 2'b00, 2'b11, 2'b00));
        push(c0 + 19, mk(2'b00, 2'b00, 2'b00, 2'b11));
        push(c0 + 22, mk(2'b00, 2'b00, 2'b00, 2'b11));
        push(c0 + 23, mk(2'b00, 2'b11, 2'b00, 2'b00));
        while (cyc < c0 + 33) begin
            @(negedge clk);
            e = pop_exp();
            n_total += 2;
            if (obs_a !== e) $display("FAIL both_a cyc=%0d got=%b exp=%b", cyc, obs_a, e);
            else n_pass++;
            if (obs_b !== e) $display("FAIL both_b cyc=%0d got=%b exp=%b", cyc, obs_b, e);
            else n_pass++;
            if (cyc == c0 + 15) begin
                n_total++;
                if (level_a !== 2'b11 || level_b !== 2'b11)
                    $display("FAIL both_level got=%b/%b exp=11", level_a, level_b);
                else n_pass++;
            end
            // Single-cycle dropouts on pin1 stay below the debounce threshold
            if (cyc >= c0 + 7 && cyc <= c0 + 14) pins[1] = ((cyc - c0 - 7) % 2) == 1;
            if (cyc == c0 + 17) pins = 2'b00;
        end
    endtask

    task automatic test_reset_held();
        int         c0;
        int         d;
        logic [7:0] e;
        c0 = cyc;
        pins[0] = 1'b1;
        push(c0 + 6,  mk(2'b01, 2'b00, 2'b00, 2'b00));
        push(c0 + 16, mk(2'b00, 2'b00, 2'b01, 2'b00));
        while (cyc < c0 + 18) begin
            @(negedge clk);
            e = pop_exp();
            n_total += 2;
            if (obs_a !== e) $display("FAIL pre_rst_a cyc=%0d got=%b exp=%b", cyc, obs_a, e);
            else n_pass++;
            if (obs_b !== e) $display("FAIL pre_rst_b cyc=%0d got=%b exp=%b", cyc, obs_b, e);
            else n_pass++;
        end
        rst_n = 1'b0;
        #1;
        n_total += 2;
        if ({level_a, obs_a} !== 10'b0) $display("FAIL async_rst_a got=%b exp=0", {level_a, obs_a});
        else n_pass++;
        if ({level_b, obs_b} !== 10'b0) $display("FAIL async_rst_b got=%b exp=0", {level_b, obs_b});
        else n_pass++;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d = cyc;
        push(d + 6,  mk(2'b01, 2'b00, 2'b00, 2'b00));
        push(d + 14, mk(2'b00, 2'b01, 2'b00, 2'b00));
        while (cyc < d + 20) begin
            @(negedge clk);
            e = pop_exp();
            n_total += 2;
            if (obs_a !== e) $display("FAIL post_rst_a cyc=%0d got=%b exp=%b", cyc, obs_a, e);
            else n_pass++;
            if (obs_b !== e) $display("FAIL post_rst_b cyc=%0d got=%b exp=%b", cyc, obs_b, e);
            else n_pass++;
            if (cyc == d + 7) begin
                n_total++;
                if (level_a !== 2'b01 || level_b !== 2'b01)
                    $display("FAIL post_rst_level got=%b/%b exp=01", level_a, level_b);
                else n_pass++;
            end
            if (cyc == d + 8) pins[0] = 1'b0;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_drained got=%0d exp=0", sb.size());
        else n_pass++;
    endtask

    initial begin
        cyc     = 0;
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_bounce();
        test_press();
        test_long_repeat();
        test_release_at_long();
        test_both_channels();
        test_reset_held();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
